// File: rtl/cmd12_request_gen.sv
// =============================================================================
// Module      : cmd12_request_gen
// Description : Counts completed data blocks of a multi-block transfer, writes
//               the decremented block count back, and requests an auto CMD12
//               once the last block is done.
//               Optional macro: SDHCI_CMD12_ON_ERROR_EN (request CMD12 on a
//               data error).
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module cmd12_request_gen #(
    parameter int CountWidth = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cmd_started_i,
    input  logic                  cmd_data_present_i,
    input  logic                  auto_cmd12_enable_i,
    input  logic                  multi_block_i,
    input  logic                  block_count_enable_i,
    input  logic [CountWidth-1:0] block_count_i,
    input  logic                  block_done_i,
    input  logic                  data_error_i,
    input  logic                  abort_i,
    input  logic                  rsp_done_i,
    output logic                  request_cmd12_o,
    output logic [CountWidth-1:0] block_count_d_o,
    output logic                  block_count_de_o,
    output logic                  active_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNTING = 2'd1,
        REQUEST  = 2'd2,
        WAIT_RSP = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [CountWidth-1:0] count_q, count_d;
    logic [CountWidth-1:0] bc_wb_q, bc_wb_d;
    logic                  bc_de_q, bc_de_d;
    logic                  request_q, request_d;
    logic                  stop_with_cmd12;
    logic                  start_ok;

    assign stop_with_cmd12 = auto_cmd12_enable_i & multi_block_i;
    // A zero count with counting enabled describes an empty transfer: never start it.
    assign start_ok = cmd_started_i & cmd_data_present_i &
                      ~(block_count_enable_i & (block_count_i == '0));

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        bc_wb_d = bc_wb_q;
        bc_de_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = COUNTING;
                    count_d = block_count_i;
                end
            end
            COUNTING: begin
                if (data_error_i) begin
`ifdef SDHCI_CMD12_ON_ERROR_EN
                    state_d = stop_with_cmd12 ? REQUEST : IDLE;
`else
                    state_d = IDLE;
`endif
                end else if (block_done_i && block_count_enable_i && (count_q != '0)) begin
                    count_d = count_q - CountWidth'(1);
                    bc_wb_d = count_d;
                    bc_de_d = 1'b1;
                    if (count_d == '0) begin
                        state_d = stop_with_cmd12 ? REQUEST : IDLE;
                    end
                end
            end
            REQUEST: begin
                state_d = WAIT_RSP;
            end
            WAIT_RSP: begin
                if (rsp_done_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort wins over everything sampled in the same cycle.
        if (abort_i) begin
            state_d = IDLE;
            count_d = count_q;
            bc_wb_d = bc_wb_q;
            bc_de_d = 1'b0;
        end
    end

    // Request flop is high exactly while the state register holds REQUEST.
    assign request_d = (state_d == REQUEST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            count_q   <= '0;
            bc_wb_q   <= '0;
            bc_de_q   <= 1'b0;
            request_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            bc_wb_q   <= bc_wb_d;
            bc_de_q   <= bc_de_d;
            request_q <= request_d;
        end
    end

    assign request_cmd12_o  = request_q;
    assign block_count_d_o  = bc_wb_q;
    assign block_count_de_o = bc_de_q;
    assign active_o         = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_cmd12_request_gen.sv
// =============================================================================
// Module      : tb_cmd12_request_gen
// Description : Directed self-checking bench for cmd12_request_gen.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_cmd12_request_gen;

    localparam int CW = 16;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          cmd_started_i = 1'b0;
    logic          cmd_data_present_i = 1'b0;
    logic          auto_cmd12_enable_i = 1'b0;
    logic          multi_block_i = 1'b0;
    logic          block_count_enable_i = 1'b0;
    logic [CW-1:0] block_count_i = '0;
    logic          block_done_i = 1'b0;
    logic          data_error_i = 1'b0;
    logic          abort_i = 1'b0;
    logic          rsp_done_i = 1'b0;
    logic          request_cmd12_o;
    logic [CW-1:0] block_count_d_o;
    logic          block_count_de_o;
    logic          active_o;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef SDHCI_CMD12_ON_ERROR_EN
    localparam logic ERR_REQ = 1'b1;
`else
    localparam logic ERR_REQ = 1'b0;
`endif

    cmd12_request_gen #(.CountWidth(CW)) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .cmd_started_i       (cmd_started_i),
        .cmd_data_present_i  (cmd_data_present_i),
        .auto_cmd12_enable_i (auto_cmd12_enable_i),
        .multi_block_i       (multi_block_i),
        .block_count_enable_i(block_count_enable_i),
        .block_count_i       (block_count_i),
        .block_done_i        (block_done_i),
        .data_error_i        (data_error_i),
        .abort_i             (abort_i),
        .rsp_done_i          (rsp_done_i),
        .request_cmd12_o     (request_cmd12_o),
        .block_count_d_o     (block_count_d_o),
        .block_count_de_o    (block_count_de_o),
        .active_o            (active_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // Advance one rising edge, then settle so outputs are sampled off the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start(input logic [CW-1:0] cnt, input logic bce, input logic auto_en, input logic multi);
        block_count_i        = cnt;
        block_count_enable_i = bce;
        auto_cmd12_enable_i  = auto_en;
        multi_block_i        = multi;
        cmd_data_present_i   = 1'b1;
        cmd_started_i        = 1'b1;
        tick();
        cmd_started_i        = 1'b0;
    endtask

    task automatic block();
        block_done_i = 1'b1;
        tick();
        block_done_i = 1'b0;
    endtask

    task automatic rsp();
        rsp_done_i = 1'b1;
        tick();
        rsp_done_i = 1'b0;
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_active", 32'(active_o), 32'd0);
        check("rst_req", 32'(request_cmd12_o), 32'd0);
        check("rst_de", 32'(block_count_de_o), 32'd0);
        check("rst_d", 32'(block_count_d_o), 32'd0);
        tick();
        rst_ni = 1'b1;
        tick();

        // Count 3, full auto CMD12 flow with back-to-back blocks
        start(16'd3, 1'b1, 1'b1, 1'b1);
        check("c3_active", 32'(active_o), 32'd1);
        block_done_i = 1'b1;
        for (int i = 2; i >= 0; i--) begin
            tick();
            check("c3_de", 32'(block_count_de_o), 32'd1);
            check("c3_d", 32'(block_count_d_o), 32'(i));
            check("c3_req", 32'(request_cmd12_o), (i == 0) ? 32'd1 : 32'd0);
        end
        block_done_i = 1'b0;
        cmd_started_i = 1'b1;  // must be ignored while busy
        tick();
        cmd_started_i = 1'b0;
        check("c3_req_once", 32'(request_cmd12_o), 32'd0);
        check("c3_de_low", 32'(block_count_de_o), 32'd0);
        check("c3_wait", 32'(active_o), 32'd1);
        tick();
        check("c3_wait_hold", 32'(active_o), 32'd1);
        rsp();
        check("c3_idle", 32'(active_o), 32'd0);
        tick();
        check("c3_no_restart", 32'(active_o), 32'd0);

        // Count 1, single block: write-back but no request
        start(16'd1, 1'b1, 1'b1, 1'b0);
        block();
        check("c1_de", 32'(block_count_de_o), 32'd1);
        check("c1_d", 32'(block_count_d_o), 32'd0);
        check("c1_req", 32'(request_cmd12_o), 32'd0);
        check("c1_idle", 32'(active_o), 32'd0);
        tick();
        check("c1_req_after", 32'(request_cmd12_o), 32'd0);

        // Count 0 with counting enabled: never starts
        start(16'd0, 1'b1, 1'b1, 1'b1);
        check("c0_active", 32'(active_o), 32'd0);
        block();
        check("c0_de", 32'(block_count_de_o), 32'd0);
        check("c0_req", 32'(request_cmd12_o), 32'd0);

        // Count 4, abort together with third block
        start(16'd4, 1'b1, 1'b1, 1'b1);
        block();
        check("ab_d1", 32'(block_count_d_o), 32'd3);
        block();
        check("ab_d2", 32'(block_count_d_o), 32'd2);
        abort_i = 1'b1;
        block_done_i = 1'b1;
        tick();
        abort_i = 1'b0;
        block_done_i = 1'b0;
        check("ab_active", 32'(active_o), 32'd0);
        check("ab_de", 32'(block_count_de_o), 32'd0);
        check("ab_d_hold", 32'(block_count_d_o), 32'd2);
        check("ab_req", 32'(request_cmd12_o), 32'd0);
        tick();
        check("ab_req_after", 32'(request_cmd12_o), 32'd0);

        // Count 4, data error together with the second block
        start(16'd4, 1'b1, 1'b1, 1'b1);
        block();
        check("er_d1", 32'(block_count_d_o), 32'd3);
        data_error_i = 1'b1;
        block_done_i = 1'b1;
        tick();
        data_error_i = 1'b0;
        block_done_i = 1'b0;
        check("er_de", 32'(block_count_de_o), 32'd0);
        check("er_d", 32'(block_count_d_o), 32'd3);
        check("er_req", 32'(request_cmd12_o), 32'(ERR_REQ));
        check("er_active", 32'(active_o), 32'(ERR_REQ));
        tick();
        rsp();
        check("er_idle", 32'(active_o), 32'd0);

        // Count 2, asynchronous reset mid-transfer
        start(16'd2, 1'b1, 1'b1, 1'b1);
        check("rs_active", 32'(active_o), 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("rs_async", 32'(active_o), 32'd0);
        tick();
        rst_ni = 1'b1;
        block();
        check("rs_de", 32'(block_count_de_o), 32'd0);
        check("rs_req", 32'(request_cmd12_o), 32'd0);
        check("rs_active_after", 32'(active_o), 32'd0);

        // Counting disabled: blocks do nothing, only abort ends it
        start(16'd0, 1'b0, 1'b1, 1'b1);
        check("nb_active", 32'(active_o), 32'd1);
        block();
        check("nb_de", 32'(block_count_de_o), 32'd0);
        check("nb_still", 32'(active_o), 32'd1);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("nb_abort", 32'(active_o), 32'd0);

        // Start without data is not a transfer
        cmd_data_present_i = 1'b0;
        cmd_started_i = 1'b1;
        block_count_i = 16'd5;
        tick();
        cmd_started_i = 1'b0;
        check("nd_active", 32'(active_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cmd12_request_gen.md
CMD12_REQUEST_GEN -- requirements
Module: cmd12_request_gen

Interface
REQ-001 SHALL have parameter CountWidth, default 16, width of the block counter and block_count ports.
REQ-002 SHALL have port clk_i  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port cmd_started_i  input  1  one-cycle pulse when the command issuer accepts a command.
REQ-005 SHALL have port cmd_data_present_i  input  1  started command carries data (0 for auto CMD12).
REQ-006 SHALL have port auto_cmd12_enable_i  input  1  transfer-mode auto CMD12 enable.
REQ-007 SHALL have port multi_block_i  input  1  transfer-mode multi-block select.
REQ-008 SHALL have port block_count_enable_i  input  1  transfer-mode block count enable.
REQ-009 SHALL have port block_count_i  input  CountWidth  block count register value.
REQ-010 SHALL have port block_done_i  input  1  one-cycle pulse per completed data block.
REQ-011 SHALL have port data_error_i  input  1  one-cycle pulse on a data CRC/end-bit/timeout error.
REQ-012 SHALL have port abort_i  input  1  data-line software reset / abort; level or pulse.
REQ-013 SHALL have port rsp_done_i  input  1  one-cycle pulse when the cmd line finishes a response.
REQ-014 SHALL have port request_cmd12_o  output  1  one-cycle pulse to queue auto CMD12 (to request_cmd12_i of the command wrapper).
REQ-015 SHALL have ports block_count_d_o  output  CountWidth and block_count_de_o  output  1  decremented block count write-back.
REQ-016 SHALL have port active_o  output  1  high whenever state is not IDLE.

Function
REQ-017 SHALL implement states IDLE, COUNTING, REQUEST, WAIT_RSP, encoded in one state register.
REQ-018 IDLE -> COUNTING SHALL occur when cmd_started_i & cmd_data_present_i, loading the counter from block_count_i, except block_count_enable_i=1 with block_count_i=0 (stay IDLE).
REQ-019 cmd_started_i in any non-IDLE state SHALL be ignored; block_done_i, data_error_i, rsp_done_i in IDLE SHALL be ignored.
REQ-020 In COUNTING with block_count_enable_i=1, each block_done_i SHALL decrement the counter by 1 and pulse block_count_de_o the same cycle with block_count_d_o = new value.
REQ-021 With block_count_enable_i=0, block_done_i SHALL neither decrement nor pulse block_count_de_o; transfer ends only by abort or error.
REQ-022 When the decrement reaches 0: if auto_cmd12_enable_i & multi_block_i -> REQUEST, else -> IDLE.
REQ-023 REQUEST SHALL assert request_cmd12_o for exactly one cycle, then go to WAIT_RSP; latency from final block_done_i to request_cmd12_o is 1 cycle.
REQ-024 WAIT_RSP -> IDLE SHALL occur on rsp_done_i.
REQ-025 abort_i SHALL force IDLE from any state next cycle with no request_cmd12_o and no block_count_de_o, winning over a simultaneous block_done_i or data_error_i.
REQ-026 data_error_i in COUNTING SHALL take priority over a simultaneous block_done_i (no decrement) and behave per REQ-032/033.
REQ-027 Counter arithmetic SHALL be modulo 2^CountWidth but SHALL never decrement below 0 (guarded by REQ-018/022).
REQ-028 request_cmd12_o and block_count_de_o SHALL be registered outputs, glitch-free.

Reset
REQ-029 On rst_ni low, state SHALL be IDLE, counter 0, request_cmd12_o 0, block_count_de_o 0, block_count_d_o 0, active_o 0.
REQ-030 Reset mid-transfer SHALL discard the transfer with no request or write-back after release.
REQ-031 First state change after reset release SHALL require a new cmd_started_i.

Configuration
REQ-032 With SDHCI_CMD12_ON_ERROR_EN defined, data_error_i in COUNTING with auto_cmd12_enable_i & multi_block_i SHALL go to REQUEST (stop on error); otherwise to IDLE.
REQ-033 Without SDHCI_CMD12_ON_ERROR_EN, data_error_i in COUNTING SHALL go to IDLE with no request_cmd12_o.

Verification
REQ-034 Count=3, enables 1, start, 3 block_done_i -> block_count_d_o 2,1,0 with de pulses, request_cmd12_o one cycle after third, active_o low after rsp_done_i.
REQ-035 Count=1, multi_block_i=0, start, 1 block_done_i -> block_count_d_o 0, no request_cmd12_o, IDLE next cycle.
REQ-036 Count=0 with block_count_enable_i=1, start -> stays IDLE, active_o 0, no outputs.
REQ-037 Count=4, after 2 blocks assert abort_i together with block_done_i -> IDLE, no de pulse, no request.
REQ-038 Count=4, data_error_i after block 1 -> request_cmd12_o pulse with SDHCI_CMD12_ON_ERROR_EN, none without; counter write-back stays 3.
REQ-039 Count=2, rst_ni low during COUNTING, release, pulse block_done_i -> no de pulse, no request.
